// File: rtl/vx_cache_responder.sv
// Memory-side endpoint of the tagged multi-lane cache protocol: flop-based word
// array with per-byte writes and a small in-order tagged response queue.
module vx_cache_responder #(
   parameter int LANES      = 4,
   parameter int DATA_SIZE  = 4,
   parameter int TAG_WIDTH  = 8,
   parameter int NUM_WORDS  = 256,
   parameter int RSP_DEPTH  = 2,
   localparam int DATA_WIDTH = 8 * DATA_SIZE,
   localparam int ADDR_WIDTH = 32 - $clog2(DATA_SIZE)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [LANES-1:0]                     req_valid,
   input  logic [LANES-1:0]                     req_rw,
   input  logic [LANES-1:0][DATA_SIZE-1:0]      req_byteen,
   input  logic [LANES-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     req_data,
   input  logic [LANES-1:0][TAG_WIDTH-1:0]      req_tag,
   output logic [LANES-1:0]                     req_ready,
   output logic                                 rsp_valid,
   output logic [LANES-1:0]                     rsp_tmask,
   output logic [LANES-1:0][DATA_WIDTH-1:0]     rsp_data,
   output logic [TAG_WIDTH-1:0]                 rsp_tag,
   input  logic                                 rsp_ready
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [DATA_WIDTH-1:0]             mem_r [NUM_WORDS];
   logic [CNT_W-1:0]                  count_r;
   logic [LANES-1:0]                  q_tmask_r [RSP_DEPTH];
   logic [LANES-1:0][DATA_WIDTH-1:0]  q_data_r  [RSP_DEPTH];
   logic [TAG_WIDTH-1:0]              q_tag_r   [RSP_DEPTH];

   logic                              accept_s;
   logic [LANES-1:0]                  fire_s;
   logic [LANES-1:0]                  rd_fire_s;
   logic [LANES-1:0]                  wr_fire_s;
   logic                              push_s;
   logic                              pop_s;
   logic [CNT_W-1:0]                  slot_s;
   logic [LANES-1:0][DATA_WIDTH-1:0]  new_data_s;
   logic [TAG_WIDTH-1:0]              new_tag_s;
   logic                              unused_addr_s;

   // Ready depends only on occupancy, and is forced low while reset is held so nothing is accepted.
   assign accept_s  = reset && (count_r < DEPTH_C);
   assign req_ready = {LANES{accept_s}};
   assign fire_s    = req_valid & req_ready;
   assign rd_fire_s = fire_s & ~req_rw;
   assign wr_fire_s = fire_s & req_rw;
   assign push_s    = |rd_fire_s;
   assign pop_s     = rsp_valid & rsp_ready;
   assign slot_s    = pop_s ? (count_r - ONE_C) : count_r;

   assign rsp_valid = (count_r != {CNT_W{1'b0}});
   assign rsp_tmask = q_tmask_r[0];
   assign rsp_data  = q_data_r[0];
   assign rsp_tag   = q_tag_r[0];

   assign unused_addr_s = ^req_addr;

   // Build the response for this cycle's read lanes from the pre-edge array.
   always_comb begin
      new_tag_s = {TAG_WIDTH{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         new_data_s[i] = rd_fire_s[i] ? mem_r[req_addr[i][IDX_W-1:0]] : {DATA_WIDTH{1'b0}};
      end
      // Descending scan so the lowest-index read lane supplies the tag.
      for (int i = LANES - 1; i >= 0; i--) begin
         new_tag_s = rd_fire_s[i] ? req_tag[i] : new_tag_s;
      end
   end

   // Byte-masked array writes; the later (higher-index) lane wins on a shared byte.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         for (int b = 0; b < DATA_SIZE; b++) begin
            if (wr_fire_s[i] && req_byteen[i][b]) begin
               mem_r[req_addr[i][IDX_W-1:0]][b*8 +: 8] <= req_data[i][b*8 +: 8];
            end
         end
      end
   end

   // Response queue kept as a shift register so the head entry is always slot 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {CNT_W{1'b0}};
         for (int k = 0; k < RSP_DEPTH; k++) begin
            q_tmask_r[k] <= {LANES{1'b0}};
            q_data_r[k]  <= {(LANES*DATA_WIDTH){1'b0}};
            q_tag_r[k]   <= {TAG_WIDTH{1'b0}};
         end
      end else begin
         if (pop_s) begin
            for (int k = 0; k < RSP_DEPTH - 1; k++) begin
               q_tmask_r[k] <= q_tmask_r[k+1];
               q_data_r[k]  <= q_data_r[k+1];
               q_tag_r[k]   <= q_tag_r[k+1];
            end
            q_tmask_r[RSP_DEPTH-1] <= {LANES{1'b0}};
            q_data_r[RSP_DEPTH-1]  <= {(LANES*DATA_WIDTH){1'b0}};
            q_tag_r[RSP_DEPTH-1]   <= {TAG_WIDTH{1'b0}};
         end
         if (push_s) begin
            for (int k = 0; k < RSP_DEPTH; k++) begin
               if (slot_s == CNT_W'(k)) begin
                  q_tmask_r[k] <= rd_fire_s;
                  q_data_r[k]  <= new_data_s;
                  q_tag_r[k]   <= new_tag_s;
               end
            end
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: doc/vx_cache_responder.md
Name: VX_cache_responder

Overview:
- Memory-side endpoint of the tagged multi-lane cache request/response protocol.
- Consumes the merged per-lane request stream that the request arbiter produces, and performs reads and writes on a local flop-based word array.
- Returns one tagged response per read-bearing request cycle, in the response format the arbiter's response demux consumes.
- Used as a scratchpad/shared-memory target, and as the functional model behind arbiter-level benches.

Parameters:
- LANES, 4, number of request lanes per cycle.
- DATA_SIZE, 4, bytes per word; DATA_WIDTH = 8*DATA_SIZE; ADDR_WIDTH = 32-CLOG2(DATA_SIZE).
- TAG_WIDTH, 8, request/response tag width, carried opaquely.
- NUM_WORDS, 256, array depth; power of two ≥2; IDX_W = CLOG2(NUM_WORDS).
- RSP_DEPTH, 2, response queue depth; ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  LANES  per-lane request valid.
- req_rw  in  LANES  1=write, 0=read.
- req_byteen  in  LANES×DATA_SIZE  write byte enables.
- req_addr  in  LANES×ADDR_WIDTH  word address.
- req_data  in  LANES×DATA_WIDTH  write data.
- req_tag  in  LANES×TAG_WIDTH  request tag.
- req_ready  out  LANES  per-lane ready; all bits always equal.
- rsp_valid  out  1  response valid.
- rsp_tmask  out  LANES  lanes carrying read data.
- rsp_data  out  LANES×DATA_WIDTH  read data; zero for lanes outside tmask.
- rsp_tag  out  TAG_WIDTH  response tag.
- rsp_ready  in  1  response consumer ready.

Behaviour:

Clock and reset:
- One clock. Reset is asynchronous and active-low.
- While reset=0: queue empty, rsp_valid=0, rsp_tmask=0, rsp_data=0, rsp_tag=0, req_ready=0.
- Array contents are not reset.
- Reset asserted mid-operation discards all queued responses immediately. A request presented in that cycle is not accepted.

Request acceptance:
- req_ready[i] = (count < RSP_DEPTH) for every lane i, where count = queue occupancy. Ready does not depend on req_valid or on a same-cycle pop.
- Lane i fires when req_valid[i] & req_ready[i]. All firing lanes of a cycle form one request group.
- Word index is req_addr[i][IDX_W-1:0]; upper address bits are ignored.

Writes:
- A firing lane with rw=1 updates the bytes selected by byteen at the rising edge. byteen=0 is a legal no-op.
- Same-cycle, same-word write conflict: per byte, the highest-index enabled lane wins.

Reads:
- A firing lane with rw=0 reads combinationally from the pre-edge array, so a same-cycle write to the same word is not visible.
- A read in the following cycle sees the write.

Response generation:
- If a group has ≥1 firing read lane, exactly one entry is pushed at the edge.
  - tmask = mask of firing read lanes.
  - data = read words for those lanes, zero elsewhere.
  - tag = req_tag of the lowest-index firing read lane; tags on other lanes are ignored.
- Write-only groups and idle cycles push nothing.

Response queue:
- FIFO of RSP_DEPTH entries.
- rsp_valid = !empty; rsp_* are driven from the head entry, which is registered.
- An entry pops when rsp_valid & rsp_ready.
- Push and pop in the same cycle leave count unchanged.
- Latency: read accepted at edge T → rsp_valid high from T+1.
- Sustained throughput is one group per cycle while rsp_ready=1.
- The queue never overflows, because pushes only happen when count<RSP_DEPTH.

Output stability:
- While rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.

Test Plan:
1. Write lanes 0–3 to addrs 0x10–0x13, data 0xA0+i, byteen=0xF; next cycle read the same addrs with tag 0x5A → one response: tmask=0xF, data={0xA3,0xA2,0xA1,0xA0}, tag=0x5A, rsp_valid first seen one cycle after acceptance.
2. Hold rsp_ready=0 and issue 3 read groups with tags 1, 2, 3 → tags 1 and 2 are queued, req_ready=0 from the third cycle, outputs hold tag 1. Release rsp_ready → responses emerge in order 1, 2, 3, with no loss or duplication.
3. Word 0x20=0x11223344; write 0xFFFFFFFF with byteen=0x5; read → 0x11FF33FF.
4. Same cycle: lane1 writes 0xAAAA0000 (byteen=0xC) and lane3 writes 0xBBBBBBBB (byteen=0x6) to word 7; lane0 reads word 7 with tag 9 → response carries the old value. A next-cycle read returns 0xAABBBB00 merged over the old byte 0.
5. Mixed group: lane0 write, lanes 1 and 2 read with tags 4 and 6, lane3 idle → tmask=0x6, tag=4, data lanes 0 and 3 zero. A write-only group produces no response.
6. Queue holding 2 entries, then reset pulled low for one cycle mid-stream → rsp_valid=0 and req_ready=0 during reset. After release, req_ready=1, no stale responses, and array data written before reset is still readable.
